thead_sync_rsp: RTL and testbench

Responder end of the cross-domain event handshake in the PMU logic. It takes a level request raised and held by the initiating domain, synchronizes it into `slow_clk`, and presents it once as a valid/ready event to local logic. It then returns an acknowledge level so the initiator can clear its request. It also keeps a saturating count of accepted events and, optionally, flags initiators that hold the request too long.

---
 rtl/thead_sync_rsp_if.sv | 29 ++
 rtl/thead_sync_rsp.sv | 143 ++++++++++++++
 tb/tb_thead_sync_rsp.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/thead_sync_rsp_if.sv
`default_nettype none
// ============================================================================
//  Module      : thead_sync_rsp_if
//  Description : Cross-domain request/acknowledge levels plus the local
//                valid/ready event channel of the PMU handshake responder.
//                master = initiator/consumer side, slave = responder.
//  Revision    : 1.0  initial release
// ============================================================================
interface thead_sync_rsp_if;
    logic req_in;   // request level from the initiating domain
    logic ack_out;  // acknowledge level back to the initiator
    logic out_vld;  // event valid toward the local consumer
    logic out_rdy;  // local consumer ready

    modport master (
        output req_in,
        output out_rdy,
        input  ack_out,
        input  out_vld
    );

    modport slave (
        input  req_in,
        input  out_rdy,
        output ack_out,
        output out_vld
    );
endinterface
`default_nettype wire

// File: rtl/thead_sync_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : thead_sync_rsp
//  Description : Responder end of the PMU cross-domain event handshake.
//                Synchronizes a held request level into slow_clk, presents
//                it once as a valid/ready event, returns an acknowledge
//                level and keeps a saturating count of accepted events.
//  Options     : THEAD_SYNC_RSP_TIMEOUT_EN - when defined, flags (to_err)
//                an initiator holding its request TO_CYCLES cycles in ACK.
//  Revision    : 1.0  initial release
// ============================================================================
module thead_sync_rsp #(
    parameter int SYNC_STAGES = 2,
    parameter int EVT_CNT_W   = 8,
    parameter int TO_CYCLES   = 1024
) (
    input  wire logic                 slow_clk,
    input  wire logic                 pad_cpu_rst,
    thead_sync_rsp_if.slave           hs,
    input  wire logic                 cnt_clr,
    output logic [EVT_CNT_W-1:0]      evt_cnt,
    output logic                      to_err
);

    // Parameter legality, caught at elaboration
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_chk_sync
        $error("thead_sync_rsp: SYNC_STAGES must be 2..4");
    end
    if (TO_CYCLES < 1) begin : g_chk_to
        $error("thead_sync_rsp: TO_CYCLES must be >= 1");
    end

    localparam logic [EVT_CNT_W-1:0] c_EVT_MAX = {EVT_CNT_W{1'b1}};
    localparam logic [EVT_CNT_W-1:0] c_EVT_ONE = EVT_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_s;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_out_vld;
    logic                   r_ack_out;
    logic                   w_vld_nxt;
    logic                   w_ack_nxt;
    logic                   w_accept;
    logic [EVT_CNT_W-1:0]   r_evt_cnt;

    // Synchronizer chain: the only logic that ever samples req_in
    always_ff @(posedge slow_clk) begin
        if (pad_cpu_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], hs.req_in};
        end
    end

    assign w_req_s  = r_sync[SYNC_STAGES-1];
    assign w_accept = (r_state == ST_VALID) && hs.out_rdy;

    // State register plus registered outputs decoded from the next state
    always_ff @(posedge slow_clk) begin
        if (pad_cpu_rst) begin
            r_state   <= ST_IDLE;
            r_out_vld <= 1'b0;
            r_ack_out <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_vld <= w_vld_nxt;
            r_ack_out <= w_ack_nxt;
        end
    end

    // Next-state logic; a request falling while VALID still waits for accept
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_req_s)   w_state_nxt = ST_VALID;
            ST_VALID: if (w_accept)  w_state_nxt = ST_ACK;
            ST_ACK:   if (!w_req_s)  w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
        w_vld_nxt = (w_state_nxt == ST_VALID);
        w_ack_nxt = (w_state_nxt == ST_ACK);
    end

    // Accepted-event counter: clear wins over count, clear+accept lands on 1
    always_ff @(posedge slow_clk) begin
        if (pad_cpu_rst) begin
            r_evt_cnt <= '0;
        end else if (cnt_clr) begin
            r_evt_cnt <= w_accept ? c_EVT_ONE : '0;
        end else if (w_accept && (r_evt_cnt != c_EVT_MAX)) begin
            r_evt_cnt <= r_evt_cnt + c_EVT_ONE;
        end
    end

    assign hs.out_vld = r_out_vld;
    assign hs.ack_out = r_ack_out;
    assign evt_cnt    = r_evt_cnt;

`ifdef THEAD_SYNC_RSP_TIMEOUT_EN
    localparam int                c_TO_W    = $clog2(TO_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX  = c_TO_W'(TO_CYCLES);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TO_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_to_err;
    logic              w_to_run;

    assign w_to_run = (r_state == ST_ACK) && w_req_s;

    // Hold-time counter; to_err is raised on the cycle the limit is reached
    always_ff @(posedge slow_clk) begin
        if (pad_cpu_rst) begin
            r_to_cnt <= '0;
            r_to_err <= 1'b0;
        end else begin
            if (!w_to_run) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != c_TO_MAX) begin
                r_to_cnt <= r_to_cnt + c_TO_ONE;
            end
            if (cnt_clr) begin
                r_to_err <= 1'b0;
            end else if (w_to_run && (r_to_cnt == c_TO_LAST)) begin
                r_to_err <= 1'b1;
            end
        end
    end

    assign to_err = r_to_err;
`else
    assign to_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_thead_sync_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_thead_sync_rsp
//  Description : Self-checking bench for thead_sync_rsp. Expected values are
//                derived from handshake latencies (SYNC_STAGES), stall counts
//                and a saturating event total.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_thead_sync_rsp;

    localparam int SYNC_STAGES = 2;
    localparam int EVT_CNT_W   = 2;
    localparam int TO_CYCLES   = 16;
    localparam int C_CNT_MAX   = (1 << EVT_CNT_W) - 1;

    logic                 slow_clk = 1'b0;
    logic                 pad_cpu_rst;
    logic                 cnt_clr;
    logic [EVT_CNT_W-1:0] evt_cnt;
    logic                 to_err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    bit exp_to;

    thead_sync_rsp_if u_if ();

    thead_sync_rsp #(
        .SYNC_STAGES (SYNC_STAGES),
        .EVT_CNT_W   (EVT_CNT_W),
        .TO_CYCLES   (TO_CYCLES)
    ) u_dut (
        .slow_clk    (slow_clk),
        .pad_cpu_rst (pad_cpu_rst),
        .hs          (u_if.slave),
        .cnt_clr     (cnt_clr),
        .evt_cnt     (evt_cnt),
        .to_err      (to_err)
    );

    always #5 slow_clk = ~slow_clk;

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit vld, input bit ack);
        check({tag, ".out_vld"}, {31'd0, u_if.out_vld}, {31'd0, vld});
        check({tag, ".ack_out"}, {31'd0, u_if.ack_out}, {31'd0, ack});
    endtask

    function automatic int sat_inc(input int v);
        return (v >= C_CNT_MAX) ? C_CNT_MAX : v + 1;
    endfunction

    // One full 4-phase handshake with a given consumer stall and ACK hold
    task automatic run_evt(input int stall, input int hold, input bit clr_at_accept);
        u_if.req_in  = 1'b1;
        u_if.out_rdy = 1'b0;
        for (int e = 0; e < SYNC_STAGES; e++) begin
            tick();
            chk_out("sync_wait", 1'b0, 1'b0);
        end
        tick();
        chk_out("vld_rise", 1'b1, 1'b0);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk_out("stall", 1'b1, 1'b0);
        end
        u_if.out_rdy = 1'b1;
        cnt_clr      = clr_at_accept;
        tick();
        cnt_clr      = 1'b0;
        u_if.out_rdy = 1'($urandom_range(0, 1));
        exp_cnt      = clr_at_accept ? 1 : sat_inc(exp_cnt);
        chk_out("accept", 1'b0, 1'b1);
        check("evt_cnt", {30'd0, evt_cnt}, exp_cnt);
        check("to_err_idle", {31'd0, to_err}, 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk_out("ack_hold", 1'b0, 1'b1);
        end
        u_if.req_in = 1'b0;
        for (int e = 0; e < SYNC_STAGES; e++) begin
            tick();
            chk_out("ack_fall_wait", 1'b0, 1'b1);
        end
        tick();
        chk_out("ack_fall", 1'b0, 1'b0);
    endtask

    initial begin
`ifdef THEAD_SYNC_RSP_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        pad_cpu_rst  = 1'b1;
        cnt_clr      = 1'b0;
        u_if.req_in  = 1'b0;
        u_if.out_rdy = 1'b0;
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0);
        check("reset.evt_cnt", {30'd0, evt_cnt}, 0);
        check("reset.to_err", {31'd0, to_err}, 0);
        pad_cpu_rst = 1'b0;
        tick();

        // basic handshake, consumer always ready
        run_evt(0, 0, 1'b0);
        // backpressure: five stalled cycles -> six cycles of valid
        run_evt(5, 1, 1'b0);
        // randomized handshakes, driving the counter into saturation
        for (int i = 0; i < 6; i++) begin
            run_evt(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b0);
        end
        check("saturated", {30'd0, evt_cnt}, C_CNT_MAX);

        // clear alone
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        exp_cnt = 0;
        check("clr_alone", {30'd0, evt_cnt}, exp_cnt);
        // clear coincident with an accept
        run_evt(int'($urandom_range(0, 3)), 0, 1'b1);

        // violation: request drops while the event is still pending
        u_if.req_in  = 1'b1;
        u_if.out_rdy = 1'b0;
        for (int e = 0; e < SYNC_STAGES; e++) tick();
        tick();
        chk_out("viol_vld", 1'b1, 1'b0);
        u_if.req_in = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk_out("viol_hold", 1'b1, 1'b0);
        end
        u_if.out_rdy = 1'b1;
        tick();
        u_if.out_rdy = 1'b0;
        exp_cnt = sat_inc(exp_cnt);
        chk_out("viol_accept", 1'b0, 1'b1);
        check("viol_cnt", {30'd0, evt_cnt}, exp_cnt);
        tick();
        chk_out("viol_idle", 1'b0, 1'b0);
        tick();
        chk_out("viol_idle2", 1'b0, 1'b0);

        // reset while in ACK with the request still high
        u_if.req_in  = 1'b1;
        u_if.out_rdy = 1'b1;
        for (int e = 0; e <= SYNC_STAGES; e++) tick();
        tick();
        exp_cnt = sat_inc(exp_cnt);
        chk_out("rst_pre_ack", 1'b0, 1'b1);
        tick();
        pad_cpu_rst = 1'b1;
        tick();
        pad_cpu_rst = 1'b0;
        exp_cnt     = 0;
        chk_out("mid_reset", 1'b0, 1'b0);
        check("mid_reset.evt_cnt", {30'd0, evt_cnt}, exp_cnt);
        check("mid_reset.to_err", {31'd0, to_err}, 0);
        for (int e = 0; e < SYNC_STAGES; e++) begin
            tick();
            chk_out("post_rst_wait", 1'b0, 1'b0);
        end
        tick();
        chk_out("post_rst_vld", 1'b1, 1'b0);
        tick();
        exp_cnt = sat_inc(exp_cnt);
        chk_out("post_rst_accept", 1'b0, 1'b1);
        check("post_rst_cnt", {30'd0, evt_cnt}, exp_cnt);
        u_if.req_in = 1'b0;
        for (int e = 0; e < SYNC_STAGES; e++) tick();
        tick();
        chk_out("post_rst_release", 1'b0, 1'b0);

        // timeout: request held in ACK
        u_if.req_in  = 1'b1;
        u_if.out_rdy = 1'b1;
        for (int e = 0; e <= SYNC_STAGES; e++) tick();
        tick();
        exp_cnt = sat_inc(exp_cnt);
        chk_out("to_accept", 1'b0, 1'b1);
        for (int k = 1; k < TO_CYCLES; k++) begin
            tick();
            check("to_before", {31'd0, to_err}, 0);
        end
        tick();
        check("to_reached", {31'd0, to_err}, {31'd0, exp_to});
        chk_out("to_still_ack", 1'b0, 1'b1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        exp_cnt = 0;
        check("to_cleared", {31'd0, to_err}, 0);
        check("to_clr_cnt", {30'd0, evt_cnt}, exp_cnt);
        u_if.req_in = 1'b0;
        for (int e = 0; e < SYNC_STAGES; e++) tick();
        tick();
        chk_out("to_release", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
